// File: rtl/mem_arbiter_pkg.sv
// Shared CPU encodings: arbiter states, core sequencing codes and bus width defaults.
package mem_arbiter_pkg;

    localparam int ADDR_LEN_DEF = 8;
    localparam int WORD_LEN_DEF = 8;

    typedef enum logic [1:0] {
        SEQ_FETCH  = 2'b00,
        SEQ_DECODE = 2'b01,
        SEQ_EXEC   = 2'b10,
        SEQ_WB     = 2'b11
    } seq_state_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_LOCK0 = 2'b01,
        ARB_LOCK1 = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port data memory,
// with a bounded lock for multi-access sequences; zero-cycle grant, reads return next cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_LEN = ADDR_LEN_DEF,
    parameter int WORD_LEN = WORD_LEN_DEF,
    parameter int MAX_LOCK = 4
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                r0_req,
    input  logic                r0_we,
    input  logic                r0_lock,
    input  logic [ADDR_LEN-1:0] r0_addr,
    input  logic [WORD_LEN-1:0] r0_wdata,
    output logic                r0_gnt,
    output logic                r0_rvalid,
    output logic [WORD_LEN-1:0] r0_rdata,

    input  logic                r1_req,
    input  logic                r1_we,
    input  logic                r1_lock,
    input  logic [ADDR_LEN-1:0] r1_addr,
    input  logic [WORD_LEN-1:0] r1_wdata,
    output logic                r1_gnt,
    output logic                r1_rvalid,
    output logic [WORD_LEN-1:0] r1_rdata,

    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic [WORD_LEN-1:0] mem_data_in,
    input  logic [WORD_LEN-1:0] mem_data_out
);

    localparam int            CW      = $clog2(MAX_LOCK + 1);
    localparam logic [CW:0]   MAX_W   = MAX_LOCK[CW:0];
    localparam logic [CW-1:0] CNT_MAX = '1;

    arb_state_t    state, state_nxt;
    logic          last, last_nxt;
    logic [CW-1:0] lock_cnt, cnt_nxt;
    logic [CW:0]   cnt_inc;
    logic [1:0]    rd_pend, rd_pend_nxt;
    logic          acc_any, acc_id, acc_lock, owner_req;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ARB_IDLE;
            last     <= 1'b1;
            lock_cnt <= '0;
            rd_pend  <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= cnt_nxt;
            rd_pend  <= rd_pend_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_nxt    = last;
        cnt_nxt     = lock_cnt;
        rd_pend_nxt = {r1_gnt & ~r1_we, r0_gnt & ~r0_we};
        acc_any     = r0_gnt | r1_gnt;
        acc_id      = r1_gnt;
        acc_lock    = r1_gnt ? r1_lock : r0_lock;
        owner_req   = (state == ARB_LOCK1) ? r1_req : r0_req;
        cnt_inc     = {1'b0, lock_cnt} + 1'b1;
        if (acc_any)
            last_nxt = acc_id;
        case (state)
            ARB_IDLE: begin
                // A single-access budget means a lock could never outlive its first access
                if (acc_any && acc_lock && MAX_LOCK > 1) begin
                    state_nxt = acc_id ? ARB_LOCK1 : ARB_LOCK0;
                    cnt_nxt   = CW'(1);
                end
            end
            ARB_LOCK0, ARB_LOCK1: begin
                if (!owner_req || !acc_lock || cnt_inc >= MAX_W) begin
                    state_nxt = ARB_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ARB_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        r0_gnt      = 1'b0;
        r1_gnt      = 1'b0;
        mem_addr    = '0;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        mem_data_in = '0;
        // Grants are gated by rstn so nothing reaches memory while reset is held
        if (rstn) begin
            case (state)
                ARB_IDLE: begin
                    if (r0_req && r1_req) begin
                        r0_gnt = last;
                        r1_gnt = ~last;
                    end else begin
                        r0_gnt = r0_req;
                        r1_gnt = r1_req;
                    end
                end
                ARB_LOCK0: r0_gnt = r0_req;
                ARB_LOCK1: r1_gnt = r1_req;
                default: ;
            endcase
        end
        if (r0_gnt) begin
            mem_addr    = r0_addr;
            mem_r_en    = ~r0_we;
            mem_w_en    = r0_we;
            mem_data_in = r0_wdata;
        end else if (r1_gnt) begin
            mem_addr    = r1_addr;
            mem_r_en    = ~r1_we;
            mem_w_en    = r1_we;
            mem_data_in = r1_wdata;
        end
    end

    assign r0_rvalid = rd_pend[0];
    assign r1_rvalid = rd_pend[1];
    assign r0_rdata  = rd_pend[0] ? mem_data_out : '0;
    assign r1_rdata  = rd_pend[1] ? mem_data_out : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port data MEMORY between the EXEC unit (requester 0) and a loader/debug port (requester 1). It performs per-cycle round-robin arbitration with an optional bounded lock for multi-access sequences such as read-modify-write. Granted reads return data exactly one cycle later. It sits between the requesters and MEMORY, replacing the direct EXEC-to-MEMORY connection.

## Interface
- ADDR_LEN, 8, memory address width
- WORD_LEN, 8, memory word width
- MAX_LOCK, 4, max consecutive accepted accesses one owner may hold under lock (≥1)

Ports (`i` ∈ {0,1}; one full set per requester):
- clk  in  1  clock, rising edge
- rstn  in  1  reset; asynchronous, active-low
- ri_req  in  1  access request
- ri_we  in  1  1 = write, 0 = read
- ri_lock  in  1  request to keep ownership after this access
- ri_addr  in  ADDR_LEN  access address
- ri_wdata  in  WORD_LEN  write data
- ri_gnt  out  1  access accepted this cycle (combinational)
- ri_rvalid  out  1  read data valid (registered)
- ri_rdata  out  WORD_LEN  read data; 0 when ri_rvalid = 0
- mem_addr  out  ADDR_LEN  to MEMORY
- mem_r_en  out  1  to MEMORY
- mem_w_en  out  1  to MEMORY
- mem_data_in  out  WORD_LEN  write data to MEMORY
- mem_data_out  in  WORD_LEN  read data from MEMORY, valid the cycle after mem_r_en

## Operation
- States: ARB_IDLE, ARB_LOCK0, ARB_LOCK1. Registers: state, last (last granted id), lock_cnt, rd_pend[1:0] (per-requester read-return flag).
- An access is accepted when ri_req & ri_gnt. At most one gnt per cycle.
- ARB_IDLE: a single requester is granted. When both request, the requester ≠ last is granted.
- ARB_LOCKk: only requester k may be granted. The other requester's gnt = 0 even if k is idle.
- Memory drive: on accept, mem_addr = ri_addr, mem_r_en = ~ri_we, mem_w_en = ri_we, mem_data_in = ri_wdata. With no accept, all mem outputs are 0.
- Read return: a read accepted in cycle n sets rd_pend[i] for cycle n+1. Then ri_rvalid = 1 and ri_rdata = mem_data_out. Writes produce no response.
- Every accept sets last = i.
- Transitions on accept by k from ARB_IDLE:
  - lock = 1 → ARB_LOCKk with lock_cnt = 1.
  - lock = 0 → stay in ARB_IDLE.
- Transitions in ARB_LOCKk:
  - Accept with lock = 1 and lock_cnt+1 < MAX_LOCK → stay, lock_cnt++.
  - Accept with lock = 0 → ARB_IDLE.
  - Accept with lock_cnt+1 = MAX_LOCK → forced ARB_IDLE regardless of lock.
  - rk_req = 0 for a cycle → ARB_IDLE (lock dropped).
- MAX_LOCK = 1 means lock never takes effect; state stays in ARB_IDLE.
- lock_cnt is $clog2(MAX_LOCK+1) bits and saturates; it never wraps.

## Timing
- gnt and mem_* are combinational from req, we, addr, wdata and state registers. Zero-cycle grant.
- Read latency: accept in cycle n → rvalid/rdata in cycle n+1. Back-to-back reads give rvalid on consecutive cycles.
- A read by 0 in cycle n followed by an accept by 1 in cycle n+1 is legal. r0_rvalid and the r1 access overlap in n+1.
- Requesters hold req/we/addr/wdata/lock stable until gnt. Withdrawing req before gnt is permitted.
- Reset (asynchronous, any time, including mid-lock or with a read pending):
  - State registers: state = ARB_IDLE, last = 1 (requester 0 wins first tie), lock_cnt = 0, rd_pend = 0.
  - Outputs: all gnt = 0, all rvalid = 0, all rdata = 0, mem_r_en = mem_w_en = 0, mem_addr = 0, mem_data_in = 0.
  - A read accepted in the cycle reset asserts returns no rvalid.

## Structure
- Shared package/header holds the state encodings ARB_IDLE = 2'b00, ARB_LOCK0 = 2'b01, ARB_LOCK1 = 2'b10, alongside the CPU's existing sequencing codes and the common ADDR_LEN/WORD_LEN defaults.
- Single module; no sub-module is warranted. The two-way pick is a few lines of combinational logic.
- The CPU top instantiates mem_arbiter between EXEC (r0) and MEMORY. r1 is tied off (req = 0) when no loader is present.

## Test plan
- Only r0 reads addr 0x10 (mem[0x10] = 0xA5) → r0_gnt = 1 in same cycle, mem_r_en = 1, mem_addr = 0x10; next cycle r0_rvalid = 1, r0_rdata = 0xA5, r1_rvalid = 0.
- After reset, both request continuously (r0 read 0x01, r1 write 0x02 ← 0x3C), no lock → grants alternate 0,1,0,1. mem[0x02] = 0x3C after the first r1 grant. No cycle has two gnts.
- r0 asserts lock with req every cycle, r1 requesting, MAX_LOCK = 4 → r0 granted 4 consecutive cycles, then r1 granted on cycle 5 (forced release, last = 0).
- r0 locks for 2 accesses, then drops lock on the 2nd → r1 granted in the following cycle; state returns to ARB_IDLE.
- r0 in ARB_LOCK0 deasserts req for one cycle while r1 requests → r1 not granted that cycle; r1 granted the next cycle.
- rstn pulsed low the cycle after an r1 read accept with lock held → r1_rvalid = 0, all gnt = 0 during reset. After release, first tie is won by r0.
